// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults and helpers for the FIFO write arbiter.
package fifo_arb_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_DEPTH = 64;
    localparam int CNT_W     = $clog2(DEF_DEPTH + 1);
    localparam int ID_W      = $clog2(DEF_NREQ);

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = ID_W
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            any
);
    always_comb begin
        gnt_id = '0;
        // Walk offsets from farthest to nearest so the nearest valid index wins.
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) gnt_id = IW'((int'(ptr) + k) % NREQ);
        any = |req;
        gnt = '0;
        gnt[gnt_id] = any;
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write sharing and occupancy tracking for one FIFO.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       pop,
    output logic                       pop_ready,
    output logic [WIDTH-1:0]           fifo_buf_in,
    output logic                       fifo_wr_en,
    output logic                       fifo_rd_en,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(NREQ)-1:0]    grant_id
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, gnt_id;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] buf_in_q, buf_in_d;
    logic             wr_en_q, rd_en_q, wr_acc, pop_acc, any;
    logic [NREQ-1:0]  gnt;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_comb begin
        full       = count_q == CW'(DEPTH);
        empty      = count_q == '0;
        wr_acc     = any && !full && !rst;
        pop_acc    = pop && !empty && !rst;
        // Ready looks only at registered full, never at pop.
        req_ready  = (rst || full) ? '0 : gnt;
        pop_ready  = !empty;
        rr_ptr_d   = wr_acc ? IW'(wrap_inc(int'(gnt_id), NREQ)) : rr_ptr_q;
        grant_id_d = wr_acc ? gnt_id : grant_id_q;
        buf_in_d   = wr_acc ? req_data[int'(gnt_id)*WIDTH +: WIDTH] : buf_in_q;
        count_d    = (wr_acc && !pop_acc) ? count_q + CW'(1) :
                     (pop_acc && !wr_acc) ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            count_q    <= '0;
            buf_in_q   <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            count_q    <= count_d;
            buf_in_q   <= buf_in_d;
            wr_en_q    <= wr_acc;
            rd_en_q    <= pop_acc;
        end
    end

    assign fifo_buf_in = buf_in_q;
    assign fifo_wr_en  = wr_en_q;
    assign fifo_rd_en  = rd_en_q;
    assign count       = count_q;
    assign grant_id    = grant_id_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed test-plan scenarios plus random traffic against a reference model.
module tb_fifo_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        pop = 1'b0;
    logic        pop_ready;
    logic [15:0] fifo_buf_in;
    logic        fifo_wr_en, fifo_rd_en, full, empty;
    logic [6:0]  count;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    int          m_ptr = 0, m_count = 0, m_gid = 0;
    logic        m_wr = 1'b0, m_rd = 1'b0, m_known = 1'b0;
    logic [15:0] m_buf = '0;

    fifo_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .pop         (pop),
        .pop_ready   (pop_ready),
        .fifo_buf_in (fifo_buf_in),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_rd_en  (fifo_rd_en),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model, cross the edge.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [63:0] d, input logic p);
        int w;
        logic [3:0] rdy_e;
        logic wa, pa;
        rst = r; req_valid = v; req_data = d; pop = p;
        #1;
        w = -1;
        for (int k = 0; k < 4; k++)
            if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        rdy_e = (r || w < 0 || m_count == 64) ? 4'b0 : 4'(1 << w);
        if (m_known) begin
            chk("req_ready", req_ready, rdy_e);
            chk("pop_ready", pop_ready, m_count > 0);
            chk("count", count, m_count);
            chk("full", full, m_count == 64);
            chk("empty", empty, m_count == 0);
            chk("wr_en", fifo_wr_en, m_wr);
            chk("rd_en", fifo_rd_en, m_rd);
            chk("buf_in", fifo_buf_in, m_buf);
            chk("grant_id", grant_id, m_gid);
        end
        wa = !r && w >= 0 && m_count < 64;
        pa = !r && p && m_count > 0;
        if (r) begin
            m_ptr = 0; m_count = 0; m_gid = 0; m_wr = 0; m_rd = 0; m_buf = '0;
            m_known = 1'b1;
        end else begin
            m_wr = wa;
            m_rd = pa;
            if (wa) begin
                m_buf = d[w*16 +: 16];
                m_gid = w;
                m_ptr = (w + 1) % 4;
            end
            m_count = m_count + int'(wa) - int'(pa);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] FAIR_D = 64'h0A03_0A02_0A01_0A00;

    initial begin
        cyc(1, 4'hF, FAIR_D, 0);
        cyc(1, 4'hF, FAIR_D, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_empty", empty, 1);
        rst = 0; req_valid = 4'hF; #1;
        chk("rel_ready", req_ready, 4'b0001);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 4'hF, FAIR_D, 0);
            chk("fair_gid", grant_id, i % 4);
            chk("fair_buf", fifo_buf_in, 16'h0A00 + 16'(i % 4));
        end
        chk("fair_count", count, 8);

        cyc(0, 4'b0010, FAIR_D, 0);
        cyc(0, 4'b1010, FAIR_D, 0);
        chk("skip_a", grant_id, 3);
        cyc(0, 4'b1010, FAIR_D, 0);
        chk("skip_b", grant_id, 1);
        cyc(0, 4'b1010, FAIR_D, 0);
        chk("skip_c", grant_id, 3);

        cyc(1, 4'h0, 64'h0, 0);
        for (int i = 0; i < 64; i++) begin
            cyc(0, 4'b0001, {48'h0, 16'(i * 30)}, 0);
            chk("full_buf", fifo_buf_in, 16'(i * 30));
        end
        chk("full_flag", full, 1);
        chk("full_count", count, 64);
        rst = 0; req_valid = 4'b0001; pop = 0; #1;
        chk("full_ready", req_ready, 4'b0000);
        cyc(0, 4'b0001, 64'h1234, 0);
        chk("full_no_wr", fifo_wr_en, 0);
        cyc(0, 4'b0000, 64'h0, 1);
        chk("pop_count", count, 63);
        chk("pop_full", full, 0);
        chk("pop_rd_en", fifo_rd_en, 1);

        cyc(1, 4'h0, 64'h0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 4'b0001, 64'h55, 0);
        cyc(0, 4'b0001, 64'h66, 1);
        chk("sim_count", count, 5);
        chk("sim_wr", fifo_wr_en, 1);
        chk("sim_rd", fifo_rd_en, 1);

        cyc(1, 4'h0, 64'h0, 0);
        rst = 0; req_valid = 4'h0; pop = 1; #1;
        chk("empty_pop_ready", pop_ready, 0);
        cyc(0, 4'h0, 64'h0, 1);
        chk("empty_no_rd", fifo_rd_en, 0);
        for (int i = 0; i < 10; i++) cyc(0, 4'hF, FAIR_D, 0);
        chk("mid_count", count, 10);
        cyc(1, 4'hF, FAIR_D, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        cyc(0, 4'h0, 64'h0, 0);
        chk("mid_no_stale", fifo_wr_en, 0);

        for (int i = 0; i < 3000; i++) begin
            logic wheavy;
            wheavy = ((i / 250) % 2) == 0;
            cyc($urandom_range(0, 299) == 0,
                4'($urandom) & (wheavy ? 4'hF : 4'($urandom)),
                {$urandom, $urandom},
                wheavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares one 16-bit `fifo` between several producers and one consumer. Round-robin arbitration picks at most one producer per cycle and drives the FIFO's `buf_in`/`wr_en`. Consumer pops are forwarded to `rd_en`. The block keeps the authoritative occupancy count, because the FIFO exports no full/empty status. It sits directly in front of the `fifo` instance and owns all of its control inputs.

## Interface
- `WIDTH`, 16, data word width; must match the FIFO's `buf_in`/`buf_out`
- `NREQ`, 4, number of producers, 2..8
- `DEPTH`, 64, FIFO capacity in words; power of two
- `clk` input 1: single clock; all state updates on the rising edge
- `rst` input 1: reset, synchronous, active-high
- `req_valid` input NREQ: producer i has a word on its data slice
- `req_data` input NREQ*WIDTH: producer i data in bits [i*WIDTH +: WIDTH]
- `req_ready` output NREQ: one-hot or zero; producer i accepted this cycle
- `pop` input 1: consumer requests one word
- `pop_ready` output 1: pop accepted this cycle (equal to `!empty`)
- `fifo_buf_in` output WIDTH: to FIFO `buf_in`, registered
- `fifo_wr_en` output 1: to FIFO `wr_en`, registered
- `fifo_rd_en` output 1: to FIFO `rd_en`, registered
- `count` output $clog2(DEPTH+1): committed occupancy
- `full` output 1: `count == DEPTH`
- `empty` output 1: `count == 0`
- `grant_id` output $clog2(NREQ): index of the last accepted producer, registered

## Operation
- **Round-robin pointer `rr_ptr`.** Searches `req_valid` from `rr_ptr` upward, with wrap-around. The first valid index found is the winner.
- **Accept rule.** `req_ready[winner] = !full`. All other bits of `req_ready` are 0. A write is accepted when valid and ready are both high.
- **Pointer update.** On an accepted write, `rr_ptr <= winner+1`, wrapping NREQ-1 to 0. With no accept, `rr_ptr` holds.
- **Pop rule.** A pop is accepted when `pop && !empty`.
- **Count update.** `count` is modified only by accepted transfers:
  - accepted write only: +1
  - accepted pop only: −1
  - both in the same cycle: unchanged
  - `count` never exceeds DEPTH and never underflows
- **Full.** A simultaneous pop does not lift `full` within the same cycle. `req_ready` depends only on the current `full`, never on the current `pop`, so there is no combinational path from `pop` to `req_ready`.
- **Empty.** A word written in cycle t becomes poppable in cycle t+1.
- **No valid requester.** No accept occurs, and `fifo_wr_en` is 0 in the next cycle.
- **Reset.** Synchronous reset wins over every other event, including a reset that arrives mid-burst. On reset:
  - `rr_ptr=0`, `count=0`, `grant_id=0`
  - `fifo_wr_en=0`, `fifo_rd_en=0`, `fifo_buf_in=0`
  - `full=0`, `empty=1`
  - In-flight transfers are dropped.
- **No FSM beyond the pointer.** The block is a pointer register, an occupancy counter and an output register stage.

## Timing
- **Write latency.** A write accepted at cycle t produces `fifo_wr_en=1` with `fifo_buf_in = req_data[winner]` during cycle t+1. The FIFO captures the word on the edge ending cycle t+1.
- **Pop latency.** A pop accepted at cycle t produces `fifo_rd_en=1` during cycle t+1.
- **Count timing.** `count`, `full` and `empty` reflect all transfers accepted up to and including cycle t−1.
- **Combinational signals.** `req_ready` and `pop_ready` are combinational from registered state and current `req_valid`/`pop`.
- **Throughput.** One write plus one pop per cycle, sustained.
- **`grant_id`.** Updates one cycle after the accept and holds otherwise.

## Structure
- **Package `fifo_arb_pkg`.**
  - default WIDTH, NREQ and DEPTH
  - localparams `CNT_W = $clog2(DEPTH+1)` and `ID_W = $clog2(NREQ)`
  - a `wrap_inc` function for the pointer
- **Sub-module `rr_arbiter`.** Inputs: `req[NREQ]`, `ptr`. Outputs: one-hot `gnt`, `gnt_id`, `any`. Purely combinational. The top level holds `rr_ptr`, `count` and the output registers.

## Test plan
- **Reset.** `rst=1` for 2 cycles with all `req_valid=1` → all outputs at their reset values, `req_ready=0`, `fifo_wr_en=0`. After release: `req_ready=4'b0001` in the first cycle.
- **Fairness.** All 4 producers valid for 8 cycles, with data 16'h0A00+i → `grant_id` sequence 0,1,2,3,0,1,2,3. `fifo_buf_in` matches each winner's data one cycle later. `count` reaches 8.
- **Skip.** Only producers 1 and 3 valid, `rr_ptr` at 2 → grant goes to 3, then 1, then 3.
- **Full.** Producer 0 streams 64 words starting at 0 and incrementing by 30 → `full=1` with `count=64`. The 65th request sees `req_ready=0` and produces no `fifo_wr_en`. A single pop gives `count=63` and `full=0` the next cycle.
- **Simultaneous.** `count=5`, with a write and a pop accepted in the same cycle → `count` stays 5, and `fifo_wr_en` and `fifo_rd_en` are both high in the next cycle.
- **Empty and mid-operation reset.** Pop while `count=0` → `pop_ready=0` and no `fifo_rd_en`. Assert `rst` for one cycle during a burst with `count=10` → `count=0` and `empty=1`, and the next cycle shows no stale `fifo_wr_en`.
